reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter data_width, default 16: width of result values carried on CDB and commit port.
REQ-002 Parameter tag_width, default 3: ROB tag width; depth is 2**tag_width entries (8 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous squash of all entries.
REQ-006 issue_valid  input  1  request to allocate one entry this cycle.
REQ-007 issue_dest  input  3  architectural destination register of issuing instruction.
REQ-008 issue_tag  output  tag_width  tag the next allocation receives; equals tail pointer.
REQ-009 full  output  1  all entries allocated; no allocation accepted.
REQ-010 CDB_in  input  CDB  result broadcast from the CDB arbiter; fields valid, tag (tag_width), data (data_width).
REQ-011 query_tag_j, query_tag_k  input  tag_width each  operand lookup tags from issue logic.
REQ-012 query_rdy_j, query_rdy_k  output  1 each  queried entry holds a completed result.
REQ-013 query_val_j, query_val_k  output  data_width each  value of queried entry.
REQ-014 commit_valid  output  1  head entry is allocated and done; it retires at the next edge.
REQ-015 commit_dest  output  3  destination register of head entry.
REQ-016 commit_data  output  data_width  result value of head entry.
REQ-017 count  output  tag_width+1  number of allocated entries, 0 to 2**tag_width.

Function
REQ-018 Each entry SHALL hold valid, done, dest[2:0], value[data_width-1:0]; head, tail and count are registers.
REQ-019 Allocation SHALL occur when issue_valid=1 and full=0: the entry at tail gets valid=1, done=0, dest=issue_dest; tail increments modulo 2**tag_width.
REQ-020 issue_valid=1 while full=1 SHALL be ignored with no state change.
REQ-021 full SHALL equal (count == 2**tag_width), computed from registered count only; a same-cycle commit does not clear full for that cycle's issue.
REQ-022 On CDB_in.valid=1, an entry at CDB_in.tag with valid=1 and done=0 SHALL get done=1 and value=CDB_in.data; broadcasts to invalid or already-done entries SHALL be ignored.
REQ-023 commit_valid, commit_dest and commit_data SHALL be combinational from the head entry; when commit_valid=1, the head entry is invalidated and head increments modulo depth at the next edge.
REQ-024 Latency: a CDB write to the head entry SHALL raise commit_valid in the following cycle, not the same cycle.
REQ-025 Simultaneous allocation and commit SHALL leave count unchanged; allocation alone adds 1; commit alone subtracts 1.
REQ-026 Allocation into the entry being committed in the same cycle cannot occur, because allocation is blocked when full.
REQ-027 query_rdy_x SHALL equal valid&done of entry query_tag_x, and query_val_x its value; query_val_x is don't-care when query_rdy_x=0.
REQ-028 flush=1 SHALL clear every valid and done bit and set head=tail=count=0 at the edge; it overrides same-cycle issue, CDB and commit.
REQ-029 Pointer wrap SHALL be seamless: after tail passes index 2**tag_width-1 it returns to 0 with no gap or stall.

Reset
REQ-030 While rst_n=0, all valid and done bits, head, tail and count SHALL be 0 immediately, regardless of clk; value and dest contents are unspecified.
REQ-031 Reset output values SHALL be full=0, issue_tag=0, count=0, commit_valid=0, query_rdy_j=query_rdy_k=0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries; the first edge after rst_n rises SHALL accept an issue at tag 0.

Configuration
REQ-033 Macro ROB_CDB_BYPASS_EN: when defined, query_rdy_x=1 and query_val_x=CDB_in.data whenever CDB_in.valid=1 and CDB_in.tag matches query_tag_x for an entry with valid=1, in the same cycle; when undefined, lookups return registered entry state only (REQ-027).

Verification
REQ-034 Issue 3 instructions (dest 1,2,3), then CDB tags 2, 0, 1 with data 0x0022, 0x0000, 0x0011 in consecutive cycles -> commits in order: dest1/0x0000, dest2/0x0011, dest3/0x0022, then count=0.
REQ-035 Issue 8 without CDB -> full=1, count=8; a 9th issue -> ignored, issue_tag stays 0; CDB tag 0 then commit -> full=0.
REQ-036 Full buffer with head done and issue_valid=1 in the commit cycle -> issue rejected, count=7; issue next cycle -> accepted at tag 0 (wrap).
REQ-037 Issue tags 0 to 4, CDB tag 3, assert flush with issue_valid=1 -> count=0, issue_tag=0, commit_valid=0 next cycle.
REQ-038 With ROB_CDB_BYPASS_EN defined: query_tag_j=1, CDB tag 1 data 0xBEEF same cycle -> query_rdy_j=1, query_val_j=0xBEEF; undefined -> query_rdy_j=0 that cycle, 1 next cycle.
REQ-039 Drop rst_n between clock edges with 5 entries live -> count=0 and commit_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order, captures results from
// the CDB, answers operand lookups, and retires completed entries from head.
//
// Parameters: data_width (result width), tag_width (depth = 2**tag_width).
// Optional feature macro: ROB_CDB_BYPASS_EN -- operand lookups also see a
// result being broadcast on the CDB in the same cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous squash of every entry
//   issue_valid, issue_dest    allocation request and its destination register
//   issue_tag, full            tag of the next allocation, no room left
//   CDB_in                     packed {valid, tag[tag_width], data[data_width]}
//   query_tag_j/k              operand lookup tags
//   query_rdy_j/k, query_val_j/k   lookup result ready flag and value
//   commit_valid/dest/data     head entry is done and retires at the next edge
//   count                      number of allocated entries
module reorder_buffer #(
  parameter int unsigned data_width = 16,
  parameter int unsigned tag_width  = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           issue_valid,
  input  logic [2:0]                     issue_dest,
  output logic [tag_width-1:0]           issue_tag,
  output logic                           full,
  input  logic [tag_width+data_width:0]  CDB_in,
  input  logic [tag_width-1:0]           query_tag_j,
  input  logic [tag_width-1:0]           query_tag_k,
  output logic                           query_rdy_j,
  output logic                           query_rdy_k,
  output logic [data_width-1:0]          query_val_j,
  output logic [data_width-1:0]          query_val_k,
  output logic                           commit_valid,
  output logic [2:0]                     commit_dest,
  output logic [data_width-1:0]          commit_data,
  output logic [tag_width:0]             count
);

  localparam int unsigned DEPTH = 2 ** tag_width;
  localparam logic [tag_width:0] FULL_COUNT = (tag_width + 1)'(DEPTH);

  // Entry state
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      done_q;
  logic [2:0]            dest_q  [DEPTH];
  logic [data_width-1:0] value_q [DEPTH];
  logic [tag_width-1:0]  head;
  logic [tag_width-1:0]  tail;

  // CDB field extraction
  logic                  cdb_valid;
  logic [tag_width-1:0]  cdb_tag;
  logic [data_width-1:0] cdb_data;
  assign cdb_valid = CDB_in[tag_width+data_width];
  assign cdb_tag   = CDB_in[tag_width+data_width-1:data_width];
  assign cdb_data  = CDB_in[data_width-1:0];

  logic alloc;
  logic retire;
  logic cdb_hit;

  // full comes from registered count only, so a same-cycle commit never frees
  // the slot for the issue arriving in that cycle.
  assign full      = (count == FULL_COUNT);
  assign issue_tag = tail;
  assign alloc     = issue_valid & ~full;
  assign cdb_hit   = cdb_valid & valid_q[cdb_tag] & ~done_q[cdb_tag];

  assign commit_valid = valid_q[head] & done_q[head];
  assign commit_dest  = dest_q[head];
  assign commit_data  = value_q[head];
  assign retire       = commit_valid;

  // Control state. The alloc/CDB/retire targets are always distinct entries:
  // alloc hits an invalid entry, CDB needs valid&~done, retire needs done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (alloc) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        tail          <= tail + 1'b1;
      end
      if (cdb_hit) begin
        done_q[cdb_tag] <= 1'b1;
      end
      if (retire) begin
        valid_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
        head          <= head + 1'b1;
      end
      if (alloc && !retire) begin
        count <= count + 1'b1;
      end else if (!alloc && retire) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload storage; contents are meaningless unless the entry is valid.
  always_ff @(posedge clk) begin
    if (alloc) begin
      dest_q[tail] <= issue_dest;
    end
    if (cdb_hit) begin
      value_q[cdb_tag] <= cdb_data;
    end
  end

  // Operand lookups
  always_comb begin
    query_rdy_j = valid_q[query_tag_j] & done_q[query_tag_j];
    query_val_j = value_q[query_tag_j];
    query_rdy_k = valid_q[query_tag_k] & done_q[query_tag_k];
    query_val_k = value_q[query_tag_k];
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_tag == query_tag_j) && valid_q[query_tag_j]) begin
      query_rdy_j = 1'b1;
      query_val_j = cdb_data;
    end
    if (cdb_valid && (cdb_tag == query_tag_k) && valid_q[query_tag_k]) begin
      query_rdy_k = 1'b1;
      query_val_k = cdb_data;
    end
`else
    // Lookups reflect registered entry state only.
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (data_width=16, tag_width=3).
module tb_reorder_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic [2:0]  issue_dest;
  logic [2:0]  issue_tag;
  logic        full;
  logic [19:0] cdb_in;
  logic [2:0]  query_tag_j;
  logic [2:0]  query_tag_k;
  logic        query_rdy_j;
  logic        query_rdy_k;
  logic [15:0] query_val_j;
  logic [15:0] query_val_k;
  logic        commit_valid;
  logic [2:0]  commit_dest;
  logic [15:0] commit_data;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  reorder_buffer #(.data_width(16), .tag_width(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_tag   (issue_tag),
    .full        (full),
    .CDB_in      (cdb_in),
    .query_tag_j (query_tag_j),
    .query_tag_k (query_tag_k),
    .query_rdy_j (query_rdy_j),
    .query_rdy_k (query_rdy_k),
    .query_val_j (query_val_j),
    .query_val_k (query_val_k),
    .commit_valid(commit_valid),
    .commit_dest (commit_dest),
    .commit_data (commit_data),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] dest);
    issue_valid = 1'b1;
    issue_dest  = dest;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
    cdb_in = {1'b1, tag, data};
  endtask

  // Advance one edge, sample 1 time unit later, then drop the one-shot inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    issue_dest  = 3'd0;
    cdb_in      = '0;
    flush       = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_dest  = 3'd0;
    cdb_in      = '0;
    query_tag_j = 3'd0;
    query_tag_k = 3'd0;

    // Reset state, before any clock edge
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_issue_tag", 32'(issue_tag), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_query_rdy_j", 32'(query_rdy_j), 32'd0);
    chk("rst_query_rdy_k", 32'(query_rdy_k), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Out-of-order completion, in-order commit
    issue(3'd1); tick();
    chk("a_count1", 32'(count), 32'd1);
    chk("a_tag1", 32'(issue_tag), 32'd1);
    issue(3'd2); tick();
    issue(3'd3); tick();
    chk("a_count3", 32'(count), 32'd3);
    chk("a_tag3", 32'(issue_tag), 32'd3);
    query_tag_j = 3'd2;
    chk("a_rdy_j_pre", 32'(query_rdy_j), 32'd0);
    cdb(3'd2, 16'h0022); tick();
    chk("a_cv_after_t2", 32'(commit_valid), 32'd0);
    chk("a_rdy_j_t2", 32'(query_rdy_j), 32'd1);
    chk("a_val_j_t2", 32'(query_val_j), 32'h0022);
    cdb(3'd0, 16'h0000);
    #1;
    chk("a_cv_same_cycle", 32'(commit_valid), 32'd0);
    tick();
    chk("a_cv1", 32'(commit_valid), 32'd1);
    chk("a_dest1", 32'(commit_dest), 32'd1);
    chk("a_data1", 32'(commit_data), 32'h0000);
    cdb(3'd1, 16'h0011); tick();
    chk("a_count_c1", 32'(count), 32'd2);
    chk("a_cv2", 32'(commit_valid), 32'd1);
    chk("a_dest2", 32'(commit_dest), 32'd2);
    chk("a_data2", 32'(commit_data), 32'h0011);
    tick();
    chk("a_cv3", 32'(commit_valid), 32'd1);
    chk("a_dest3", 32'(commit_dest), 32'd3);
    chk("a_data3", 32'(commit_data), 32'h0022);
    tick();
    chk("a_count0", 32'(count), 32'd0);
    chk("a_cv_empty", 32'(commit_valid), 32'd0);

    // Fill to full from a clean start
    flush = 1'b1; tick();
    chk("b_flush_tag", 32'(issue_tag), 32'd0);
    for (int i = 0; i < 8; i++) begin
      issue(3'(i)); tick();
    end
    chk("b_full", 32'(full), 32'd1);
    chk("b_count8", 32'(count), 32'd8);
    chk("b_tag_wrap", 32'(issue_tag), 32'd0);
    issue(3'd7); tick();
    chk("b_9th_count", 32'(count), 32'd8);
    chk("b_9th_tag", 32'(issue_tag), 32'd0);
    cdb(3'd0, 16'h1234); tick();
    chk("b_cv", 32'(commit_valid), 32'd1);
    chk("b_cdest", 32'(commit_dest), 32'd0);
    chk("b_cdata", 32'(commit_data), 32'h1234);
    chk("b_still_full", 32'(full), 32'd1);

    // Issue in the commit cycle of a full buffer is rejected
    issue(3'd5); tick();
    chk("c_count7", 32'(count), 32'd7);
    chk("c_full0", 32'(full), 32'd0);
    chk("c_tag0", 32'(issue_tag), 32'd0);
    chk("c_cv0", 32'(commit_valid), 32'd0);
    issue(3'd6); tick();
    chk("c_count8", 32'(count), 32'd8);
    chk("c_tag1", 32'(issue_tag), 32'd1);
    query_tag_k = 3'd0;
    #1;
    chk("c_rdy_k_wrapped", 32'(query_rdy_k), 32'd0);
    cdb(3'd0, 16'hAAAA); tick();
    chk("c_rdy_k_done", 32'(query_rdy_k), 32'd1);
    chk("c_val_k", 32'(query_val_k), 32'hAAAA);
    chk("c_cv_not_head", 32'(commit_valid), 32'd0);
    cdb(3'd0, 16'h5555); tick();
    chk("c_val_k_nooverwrite", 32'(query_val_k), 32'hAAAA);

    // Flush overrides a same-cycle issue
    flush = 1'b1; tick();
    chk("d_flush_count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      issue(3'(i)); tick();
    end
    cdb(3'd3, 16'h0033); tick();
    flush = 1'b1; issue(3'd4); tick();
    chk("d_count", 32'(count), 32'd0);
    chk("d_tag", 32'(issue_tag), 32'd0);
    chk("d_cv", 32'(commit_valid), 32'd0);
    query_tag_j = 3'd3;
    #1;
    chk("d_rdy_j_cleared", 32'(query_rdy_j), 32'd0);

    // Same-cycle CDB lookup
    issue(3'd2); tick();
    issue(3'd4); tick();
    query_tag_j = 3'd1;
    cdb(3'd1, 16'hBEEF);
    #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("e_bypass_rdy", 32'(query_rdy_j), 32'd1);
    chk("e_bypass_val", 32'(query_val_j), 32'hBEEF);
`else
    chk("e_nobypass_rdy", 32'(query_rdy_j), 32'd0);
`endif
    tick();
    chk("e_rdy_next", 32'(query_rdy_j), 32'd1);
    chk("e_val_next", 32'(query_val_j), 32'hBEEF);

    // Asynchronous reset between edges with 5 live entries
    issue(3'd1); tick();
    issue(3'd2); tick();
    issue(3'd3); tick();
    cdb(3'd0, 16'h0777); tick();
    chk("f_count5", 32'(count), 32'd5);
    chk("f_cv_pre", 32'(commit_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_async_count", 32'(count), 32'd0);
    chk("f_async_cv", 32'(commit_valid), 32'd0);
    chk("f_async_tag", 32'(issue_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    query_tag_k = 3'd0;
    issue(3'd3); tick();
    chk("f_post_count", 32'(count), 32'd1);
    chk("f_post_tag", 32'(issue_tag), 32'd1);
    chk("f_post_rdy_k", 32'(query_rdy_k), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
